// File: rtl/sipo_frame_pkg.sv
// rtl/sipo_frame_pkg.sv - shared state type and sizing helpers for the SIPO frame receiver
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Bit counter width; never narrower than one bit so WIDTH=2 still has a counter.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - serial-in/parallel-out shift register, shifts in at the MSB
module sipo_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {si, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - serial frame receiver controller with a one-word valid/ready output
// Optional parity check enabled by defining SIPO_FRAME_CTRL_PARITY_CHK_EN.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, overrun_q, parity_err_q;
  logic             shift_en, stop_hit, good_stop, load;
  logic             par_bad;

`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
  logic par_bad_q;
  assign par_bad = par_bad_q;
`else
  logic unused_odd_parity;
  assign par_bad           = 1'b0;
  assign unused_odd_parity = ODD_PARITY;
`endif

  assign shift_en = si_en && (state_q == DATA);

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .si       (si),
    .q        (sr)
  );

  // A new word may replace the held one only if the consumer takes it in the same cycle.
  always_comb begin
    stop_hit  = si_en && (state_q == STOP);
    good_stop = stop_hit && si && !par_bad;
    load      = good_stop && (!valid_q || ready_i);
    valid_d   = valid_q;
    data_d    = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = sr;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
      par_bad_q    <= 1'b0;
`endif
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= stop_hit && !si;
      parity_err_q <= stop_hit && par_bad;
      overrun_q    <= good_stop && !load;
      if (si_en) begin
        case (state_q)
          IDLE: begin
            if (!si) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
              state_q <= PAR;
`else
              state_q <= STOP;
`endif
            end
          end
          PAR: begin
`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
            par_bad_q <= ((^sr) ^ ODD_PARITY) != si;
`endif
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign parity_err_o = parity_err_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !ready_i) |=> (valid_q && $stable(data_q)));

  a_overrun_only_good: assert property (@(posedge clk) disable iff (rst)
    overrun_q |-> !frame_err_q);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - self-checking bench for sipo_frame_ctrl (WIDTH=4, even parity)
module tb_sipo_frame_ctrl;

  localparam int W   = 4;
  localparam bit ODD = 1'b0;

  logic         clk = 1'b0;
  logic         rst, si, si_en, ready_i;
  logic [W-1:0] data_o;
  logic         valid_o, busy_o, frame_err_o, overrun_o, parity_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .ODD_PARITY(ODD)) dut (
    .clk          (clk),
    .rst          (rst),
    .si           (si),
    .si_en        (si_en),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  // Frame-level reference: one output slot plus expected pulses, updated per strobe kind.
  logic         m_valid, m_busy, m_ov, m_fe, m_pe;
  logic [W-1:0] m_data;
  logic [W-1:0] cur_word;
  logic         cur_par_ok;

  typedef struct {
    logic [W-1:0] w;
    logic         stop;
    logic         rdy;
    logic [W-1:0] e_data;
    logic         e_valid;
    logic         e_fe;
    logic         e_ov;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_busy = 1'b0;
    m_ov = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
  endtask

  function automatic logic rr(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // kind: 0 plain cycle/data bit, 1 start strobe, 2 stop strobe
  task automatic step(input logic en, input logic s, input logic rdy, input int kind);
    logic good;
    si_en = en; si = s; ready_i = rdy;
    m_ov = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    if (en && kind == 2) begin
      good   = s && cur_par_ok;
      m_fe   = !s;
      m_pe   = !cur_par_ok;
      m_busy = 1'b0;
      if (good && (!m_valid || rdy)) begin
        m_valid = 1'b1;
        m_data  = cur_word;
      end else if (good) begin
        m_ov = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end else begin
      if (en && kind == 1) m_busy = 1'b1;
      if (m_valid && rdy) m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("mdl_valid", valid_o, m_valid);
    chk("mdl_data", data_o, m_data);
    chk("mdl_busy", busy_o, m_busy);
    chk("mdl_overrun", overrun_o, m_ov);
    chk("mdl_frame_err", frame_err_o, m_fe);
    chk("mdl_parity_err", parity_err_o, m_pe);
  endtask

  task automatic gap_cycles(input int gap, input bit rnd);
    for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), rr(rnd), 0);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop, input logic par_bad,
                            input logic rdy_stop, input int gap, input bit rnd);
    cur_word   = w;
    cur_par_ok = !par_bad;
    gap_cycles(gap, rnd);
    step(1'b1, 1'b0, rr(rnd), 1);
    for (int i = 0; i < W; i++) begin
      gap_cycles(gap, rnd);
      step(1'b1, w[i], rr(rnd), 0);
    end
`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
    gap_cycles(gap, rnd);
    step(1'b1, (^w) ^ ODD ^ par_bad, rr(rnd), 0);
`endif
    gap_cycles(gap, rnd);
    step(1'b1, stop, rnd ? rr(rnd) : rdy_stop, 2);
  endtask

  initial begin
    logic [W-1:0] rw;
    logic         rstop, rpb;

    tbl[0] = '{4'b1101, 1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'b0011, 1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{4'b0011, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'b1010, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'b1001, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{4'b0110, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; si = 1'b1; si_en = 1'b0; ready_i = 1'b0;
    cur_word = '0; cur_par_ok = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 4'b0000);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_pulses", {frame_err_o, overrun_o, parity_err_o}, 3'b000);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0, 0);

    // Good frame, held for 10 cycles, then consumed
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("good_data", data_o, 4'b1101);
    chk("good_valid", valid_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_data", data_o, 4'b1101);
    end
    step(1'b0, 1'b1, 1'b1, 0);
    chk("consume_valid", valid_o, 1'b0);

    // Framing error
    send_frame(4'b1101, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("ferr_pulse", frame_err_o, 1'b1);
    chk("ferr_valid", valid_o, 1'b0);
    chk("ferr_busy", busy_o, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("ferr_single", frame_err_o, 1'b0);

    // Table: overrun, simultaneous consume/load, errors with held word
    for (int k = 0; k < 6; k++) begin
      send_frame(tbl[k].w, tbl[k].stop, 1'b0, tbl[k].rdy, 0, 1'b0);
      chk("tbl_data", data_o, tbl[k].e_data);
      chk("tbl_valid", valid_o, tbl[k].e_valid);
      chk("tbl_frame_err", frame_err_o, tbl[k].e_fe);
      chk("tbl_overrun", overrun_o, tbl[k].e_ov);
    end
    step(1'b0, 1'b1, 1'b1, 0);

    // Gapped strobes: every 3rd cycle, glitchy si in between
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    chk("gap_data", data_o, 4'b1101);
    chk("gap_valid", valid_o, 1'b1);
    step(1'b0, 1'b1, 1'b1, 0);

`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
    send_frame(4'b1101, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("par_err_pulse", parity_err_o, 1'b1);
    chk("par_err_drop", valid_o, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("par_err_single", parity_err_o, 1'b0);
`else
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("nopar_valid", valid_o, 1'b1);
    chk("nopar_data", data_o, 4'b1101);
    chk("nopar_perr", parity_err_o, 1'b0);
    step(1'b0, 1'b1, 1'b1, 0);
`endif

    // Asynchronous reset in the middle of DATA with a word held
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cur_word = 4'b1010;
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("mid_busy_before", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_data", data_o, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_frame(4'b0101, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("post_rst_data", data_o, 4'b0101);

    // Randomized frames with random ready, gaps and errors
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) step(1'b1, 1'b1, rr(1'b1), 0);
      rw    = 4'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
`ifdef SIPO_FRAME_CTRL_PARITY_CHK_EN
      rpb   = ($urandom_range(0, 4) == 0);
`else
      rpb   = 1'b0;
`endif
      send_frame(rw, rstop, rpb, 1'b0, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Serial frame receiver controller that sequences a serial-in/parallel-out shift register.
- Detects a start bit, shifts in WIDTH data bits LSB-first, and can check a parity bit. Checks the stop bit, then presents the word on a valid/ready parallel output.
- Sits between a bit-strobed serial source (sampler/deserializer front end) and a parallel consumer.

Parameters:
- WIDTH, 4, number of data bits per frame (2..32).
- ODD_PARITY, 0, parity sense when PARITY_CHK_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- si  in  1  serial data bit.
- si_en  in  1  bit strobe; si is sampled only in cycles where si_en=1.
- data_o  out  WIDTH  received word; first data bit received is at data_o[0].
- valid_o  out  1  data_o holds an unconsumed word.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- busy_o  out  1  frame in progress (state != IDLE).
- frame_err_o  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun_o  out  1  one-cycle pulse: completed word dropped because the output was still occupied.
- parity_err_o  out  1  one-cycle pulse: parity mismatch. Constant 0 without PARITY_CHK_EN.

Behaviour:
- Reset (async, any time including mid-frame):
  - state=IDLE, shift register=0, bit counter=0.
  - data_o=0, valid_o=0, busy_o=0, all error pulses=0.
- State machine, advancing only on cycles with si_en=1; without si_en, state, counter and shift register hold.
  - IDLE: si_en && si==0 (start bit) -> DATA, counter=0. si==1 stays IDLE.
  - DATA: shift register <= {si, sr[WIDTH-1:1]}, counter++. On the bit where counter==WIDTH-1: go to PAR if the feature is present, else STOP.
  - PAR: sample si as the parity bit, -> STOP. The parity result is held until the stop bit.
  - STOP:
    - si==1: frame good -> IDLE, deliver word.
    - si==0: frame_err_o pulses the next cycle, word discarded -> IDLE.
    - A bad-parity word is discarded with parity_err_o pulsing the next cycle, even if the stop bit is good. If both are bad, both pulse.
- Delivery, registered: valid_o and data_o update on the clock edge that samples a good stop bit, so they are visible the following cycle.
  - If valid_o=0, or valid_o && ready_i in that same cycle: data_o <= shift register, valid_o stays/sets 1, no overrun.
  - If valid_o=1 && ready_i=0: data_o unchanged, overrun_o pulses one cycle.
- Handshake:
  - valid_o, once high, stays high and data_o stays stable until a cycle with ready_i=1.
  - valid_o clears on that edge unless a new word loads simultaneously.
  - ready_i while valid_o=0 has no effect.
- Reception continues while valid_o is high, giving one word of buffering.
- busy_o=1 in DATA, PAR and STOP.
- Minimum frame length: WIDTH+2 strobes (WIDTH+3 with parity).
- si_en may be asserted every cycle.

Optional Feature:
- Macro: SIPO_FRAME_CTRL_PARITY_CHK_EN.
- Defined:
  - PAR state exists.
  - Parity = XOR of the data bits, XOR ODD_PARITY, compared with the received parity bit.
  - parity_err_o is active.
- Undefined:
  - No PAR state; DATA goes directly to STOP.
  - parity_err_o is tied 0 and the port list is unchanged.

Decomposition:
- Package sipo_frame_pkg:
  - state enum typedef (IDLE, DATA, PAR, STOP), 2 bits.
  - localparam for the counter width, $clog2(WIDTH).
- Sub-module sipo_shreg (WIDTH parameter; ports clk, rst, shift_en, si, q) is the datapath shift register: async clear, shifts in at the MSB.
- The controller drives shift_en = si_en && state==DATA.

Test Plan (WIDTH=4, even parity when enabled):
- Reset then idle: no strobes -> data_o=0, valid_o=0, busy_o=0. rst asserted mid-DATA -> immediate return to IDLE, busy_o=0.
- Good frame: strobes si=0,1,0,1,1,(parity 1),1 with ready_i=0 -> data_o=4'b1101, valid_o=1 the cycle after the stop strobe, held for 10 cycles. ready_i=1 for one cycle -> valid_o=0 next cycle.
- Framing error: same data with stop bit 0 -> frame_err_o single pulse, valid_o stays 0, busy_o=0.
- Overrun: first word 4'b1101 unconsumed, second frame 4'b0011 arrives -> overrun_o pulse, data_o remains 4'b1101. Repeat with ready_i=1 on the stop-sample cycle -> data_o=4'b0011, valid_o stays 1, no overrun.
- Gapped strobes: si_en high only every 3rd cycle, with a glitchy si between strobes -> same 4'b1101 result.
- Parity (macro defined): 4'b1101 sent with parity bit 0 -> parity_err_o pulse, word dropped. Macro undefined: 6-strobe frame accepted, parity_err_o always 0.
